chunked_addsub: RTL and testbench

- Parametrised multi-cycle adder/subtractor built on the team's full-adder cell.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, through one shared CHUNK-bit ripple stage.
- Trades latency for area. Used wherever a wide add is not timing-critical, such as accumulators and address or offset math in control paths.
- Start/done handshake; the result is registered and held until the next operation completes.

---
 rtl/chunked_addsub_pkg.sv | 27 ++
 rtl/chunked_addsub_if.sv | 27 ++
 rtl/chunked_addsub_chunk_adder.sv | 26 ++
 rtl/chunked_addsub.sv | 153 +++++++++++++++
 tb/tb_chunked_addsub.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chunked_addsub_pkg.sv
// Shared definitions for the chunked adder/subtractor: FSM encoding,
// chunk-count derivation and parameter legality helpers.
package chunked_addsub_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of CHUNK-bit slices that make up a WIDTH-bit operand.
    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Width of the chunk index counter; never narrower than one bit.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

    // A configuration is usable only if the chunks tile the operand exactly.
    function automatic bit cfg_legal(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/chunked_addsub_if.sv
// Start/done handshake and operand/result bus of the chunked adder.
// The master issues operations; the slave (the arithmetic block) answers.
interface chunked_addsub_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    modport master (
        output start, sub, A, B, Cin,
        input  ready, busy, done, Sum, Cout, Ovf
    );

    modport slave (
        input  start, sub, A, B, Cin,
        output ready, busy, done, Sum, Cout, Ovf
    );
endinterface

// File: rtl/chunked_addsub_chunk_adder.sv
// Combinational CHUNK-bit ripple adder made of full-adder cells. Also
// exposes the carry into the top bit so the caller can derive signed
// overflow when this slice holds the operand MSB.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);
    logic [CHUNK:0] w_carry;

    assign w_carry[0] = cin;

    genvar gi;
    for (gi = 0; gi < CHUNK; gi++) begin : g_fa
        assign sum[gi]       = a[gi] ^ b[gi] ^ w_carry[gi];
        assign w_carry[gi+1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
    end

    assign cout     = w_carry[CHUNK];
    assign c_msb_in = w_carry[CHUNK-1];
endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor. One shared CHUNK-bit ripple
// stage processes the captured operands LSB chunk first, one chunk per
// clock. Subtraction is A + ~B + 1 (or + 0 with borrow-in). Results are
// only published when the last chunk completes.
module chunked_addsub
    import chunked_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    chunked_addsub_if.slave bus
);
    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if (!cfg_legal(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("chunked_addsub: CHUNK must divide WIDTH and lie in 1..WIDTH");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic               w_capture;
    logic               w_step;
    logic               w_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;

    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic [31:0]        w_base;
    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK-1:0]   w_sum_chunk;
    logic               w_cout_chunk;
    logic               w_c_msb;
    logic [WIDTH-1:0]   w_res_merged;

    assign w_last = (r_idx == LAST_IDX);

    // Slice the captured operands at the current chunk index.
    assign w_base    = 32'(r_idx) * 32'(CHUNK);
    assign w_a_chunk = r_a[w_base +: CHUNK];
    assign w_b_chunk = r_b[w_base +: CHUNK];

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a        (w_a_chunk),
        .b        (w_b_chunk),
        .cin      (r_carry),
        .sum      (w_sum_chunk),
        .cout     (w_cout_chunk),
        .c_msb_in (w_c_msb)
    );

    // Working result with the current chunk replaced by this cycle's sum.
    genvar gi;
    for (gi = 0; gi < NCHUNK; gi++) begin : g_merge
        localparam logic [IDX_W-1:0] GI_IDX = IDX_W'(gi);
        assign w_res_merged[gi*CHUNK +: CHUNK] =
            (r_idx == GI_IDX) ? w_sum_chunk : r_res[gi*CHUNK +: CHUNK];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; start is honoured only when ready (IDLE or DONE).
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = ST_RUN;
                    w_capture    = 1'b1;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    w_state_next = ST_RUN;
                    w_capture    = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture, then one chunk of ripple per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (w_capture) begin
            r_a     <= bus.A;
            r_b     <= bus.B ^ {WIDTH{bus.sub}};
            r_carry <= bus.Cin ^ bus.sub;
            r_idx   <= '0;
        end else if (w_step) begin
            r_res   <= w_res_merged;
            r_carry <= w_cout_chunk;
            r_idx   <= w_last ? '0 : r_idx + 1'b1;
        end
    end

    // Published result: loads only on the final chunk so partial sums never show.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_step && w_last) begin
            r_sum  <= w_res_merged;
            r_cout <= w_cout_chunk;
            r_ovf  <= w_cout_chunk ^ w_c_msb;
        end
    end

    assign bus.ready = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign bus.busy  = (r_state == ST_RUN);
    assign bus.done  = (r_state == ST_DONE);
    assign bus.Sum   = r_sum;
    assign bus.Cout  = r_cout;
    assign bus.Ovf   = r_ovf;
endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub: directed handshake/arithmetic cases on the
// default 32/8 configuration, then random sweeps on 32/32, 32/1 and 16/4.
module tb_chunked_addsub;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc   = 0;
    int          checks = 0;
    int          errors = 0;
    bit          sweep_go = 1'b0;
    int          sweeps_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int unsigned issue;
    } exp_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference arithmetic straight from the definition of add/subtract.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub, input int unsigned issue);
        logic [63:0] mask, lomask, bb, full, lo, c0;
        exp_t e;
        mask   = (64'd1 << w) - 64'd1;
        lomask = (64'd1 << (w - 1)) - 64'd1;
        bb     = sub ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
        c0     = {63'd0, cin ^ sub};
        full   = ({32'd0, a} & mask) + bb + c0;
        lo     = ({32'd0, a} & lomask) + (bb & lomask) + c0;
        e.sum   = full[31:0] & mask[31:0];
        e.cout  = full[w];
        e.ovf   = lo[w-1] ^ full[w];
        e.issue = issue;
        return e;
    endfunction

    // ---------------- default configuration (32/8) ----------------
    chunked_addsub_if #(.WIDTH(32)) bus0 ();
    chunked_addsub #(.WIDTH(32), .CHUNK(8)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    exp_t q0[$];
    exp_t e0;

    always @(negedge clk) begin
        if (rst_n && bus0.done) begin
            if (q0.size() == 0) begin
                check("dut0_unexpected_done", 64'(bus0.done), 64'd0);
            end else begin
                e0 = q0.pop_front();
                check("dut0_sum", 64'(bus0.Sum), 64'(e0.sum));
                check("dut0_cout", 64'(bus0.Cout), 64'(e0.cout));
                check("dut0_ovf", 64'(bus0.Ovf), 64'(e0.ovf));
                check("dut0_latency", 64'(cyc - e0.issue), 64'd4);
                $display("dut0 op: Sum=%08h Cout=%0b Ovf=%0b latency=%0d",
                         bus0.Sum, bus0.Cout, bus0.Ovf, cyc - e0.issue);
            end
        end
    end

    task automatic drive0(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        int n;
        n = 0;
        while (!bus0.ready && n < 20) begin @(negedge clk); n++; end
        if (!bus0.ready) check("dut0_ready_timeout", 64'(bus0.ready), 64'd1);
        bus0.A = a; bus0.B = b; bus0.Cin = cin; bus0.sub = sub; bus0.start = 1'b1;
        q0.push_back(model(32, a, b, cin, sub, cyc + 1));
        @(negedge clk);
        bus0.start = 1'b0;
    endtask

    task automatic drain0(input string tag);
        int n;
        n = 0;
        while (!bus0.done && n < 20) begin @(negedge clk); n++; end
        check({tag, "_done_seen"}, 64'(bus0.done), 64'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(bus0.done), 64'd0);
        check({tag, "_sb_empty"}, 64'(q0.size()), 64'd0);
    endtask

    // ---------------- sweep configurations ----------------
    function automatic int cfg_w(input int i);
        case (i)
            0:       return 32;
            1:       return 32;
            default: return 16;
        endcase
    endfunction

    function automatic int cfg_c(input int i);
        case (i)
            0:       return 32;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int W = cfg_w(gi);
        localparam int C = cfg_c(gi);
        localparam int N = W / C;

        chunked_addsub_if #(.WIDTH(W)) bus ();
        chunked_addsub #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        exp_t q[$];
        exp_t e_m;

        always @(negedge clk) begin
            if (rst_n && bus.done) begin
                if (q.size() == 0) begin
                    check($sformatf("cfg%0d_unexpected_done", gi), 64'(bus.done), 64'd0);
                end else begin
                    e_m = q.pop_front();
                    check($sformatf("cfg%0d_sum", gi), 64'(bus.Sum), 64'(e_m.sum));
                    check($sformatf("cfg%0d_cout", gi), 64'(bus.Cout), 64'(e_m.cout));
                    check($sformatf("cfg%0d_ovf", gi), 64'(bus.Ovf), 64'(e_m.ovf));
                    check($sformatf("cfg%0d_latency", gi), 64'(cyc - e_m.issue), 64'(N));
                    $display("cfg%0d W=%0d C=%0d op: Sum=%08h Cout=%0b Ovf=%0b latency=%0d",
                             gi, W, C, bus.Sum, bus.Cout, bus.Ovf, cyc - e_m.issue);
                end
            end
        end

        initial begin
            logic [31:0] a, b;
            logic        cin, sb;
            int          n;
            bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.sub = 1'b0;
            wait (sweep_go);
            @(negedge clk);
            for (int k = 0; k < 1000; k++) begin
                n = 0;
                while (!bus.ready && n < N + 10) begin @(negedge clk); n++; end
                if (!bus.ready) check($sformatf("cfg%0d_ready_timeout", gi), 64'(bus.ready), 64'd1);
                a   = (k % 8 == 0) ? 32'hFFFF_FFFF : $urandom;
                b   = (k % 8 == 4) ? 32'h7FFF_FFFF : $urandom;
                cin = 1'($urandom_range(0, 1));
                sb  = 1'($urandom_range(0, 1));
                bus.A = a[W-1:0]; bus.B = b[W-1:0]; bus.Cin = cin; bus.sub = sb;
                bus.start = 1'b1;
                q.push_back(model(W, a, b, cin, sb, cyc + 1));
                @(negedge clk);
                // Scramble inputs after capture; sometimes poke start while RUN.
                bus.A = W'($urandom); bus.B = W'($urandom);
                bus.Cin = ~cin; bus.sub = ~sb;
                bus.start = 1'($urandom_range(0, 1));
                @(negedge clk);
                bus.start = 1'b0;
                n = 0;
                while (!bus.done && n < N + 5) begin @(negedge clk); n++; end
                if (!bus.done) check($sformatf("cfg%0d_done_timeout", gi), 64'(bus.done), 64'd1);
                if ($urandom_range(0, 1) == 0) begin
                    repeat ($urandom_range(1, 2)) @(negedge clk);
                end
            end
            @(negedge clk);
            @(negedge clk);
            check($sformatf("cfg%0d_sb_empty", gi), 64'(q.size()), 64'd0);
            sweeps_done++;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int          n;
        int unsigned t1;
        bus0.start = 1'b0; bus0.A = '0; bus0.B = '0; bus0.Cin = 1'b0; bus0.sub = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(bus0.ready), 64'd1);
        check("rst_busy", 64'(bus0.busy), 64'd0);
        check("rst_done", 64'(bus0.done), 64'd0);
        check("rst_sum", 64'(bus0.Sum), 64'd0);
        check("rst_cout", 64'(bus0.Cout), 64'd0);
        check("rst_ovf", 64'(bus0.Ovf), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Add with carry-out.
        drive0(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        check("add_busy", 64'(bus0.busy), 64'd1);
        check("add_ready_low", 64'(bus0.ready), 64'd0);
        drain0("add_cout");
        check("add_cout_sum", 64'(bus0.Sum), 64'h0);
        check("add_cout_cout", 64'(bus0.Cout), 64'd1);
        check("add_cout_ovf", 64'(bus0.Ovf), 64'd0);

        // Signed overflow.
        drive0(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        drain0("ovf");
        check("ovf_sum", 64'(bus0.Sum), 64'h8000_0000);
        check("ovf_cout", 64'(bus0.Cout), 64'd0);
        check("ovf_ovf", 64'(bus0.Ovf), 64'd1);

        // Subtract with borrow, then with borrow-in.
        drive0(32'd5, 32'd7, 1'b0, 1'b1);
        drain0("sub");
        check("sub_sum", 64'(bus0.Sum), 64'hFFFF_FFFE);
        check("sub_cout", 64'(bus0.Cout), 64'd0);
        check("sub_ovf", 64'(bus0.Ovf), 64'd0);
        drive0(32'd5, 32'd7, 1'b1, 1'b1);
        drain0("sub_bin");
        check("sub_bin_sum", 64'(bus0.Sum), 64'hFFFF_FFFD);

        // start mid-RUN with different operands is ignored; inputs after capture are inert.
        drive0(32'd100, 32'd23, 1'b0, 1'b0);
        bus0.A = 32'hDEAD_0000; bus0.B = 32'h0000_BEEF; bus0.Cin = 1'b1; bus0.sub = 1'b1;
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        drain0("midrun");
        check("midrun_sum", 64'(bus0.Sum), 64'd123);
        repeat (6) @(negedge clk);
        check("midrun_no_extra", 64'(bus0.done), 64'd0);

        // Back-to-back: start held in the DONE cycle.
        drive0(32'd10, 32'd20, 1'b0, 1'b0);
        n = 0;
        while (!bus0.done && n < 20) begin @(negedge clk); n++; end
        check("b2b_first_done", 64'(bus0.done), 64'd1);
        t1 = cyc;
        bus0.A = 32'h1111; bus0.B = 32'h2222; bus0.Cin = 1'b0; bus0.sub = 1'b0;
        bus0.start = 1'b1;
        q0.push_back(model(32, 32'h1111, 32'h2222, 1'b0, 1'b0, cyc + 1));
        @(negedge clk);
        bus0.start = 1'b0;
        n = 0;
        while (!bus0.done && n < 20) begin
            check("b2b_sum_hold", 64'(bus0.Sum), 64'd30);
            @(negedge clk);
            n++;
        end
        check("b2b_period", 64'(cyc - t1), 64'd5);
        check("b2b_second_sum", 64'(bus0.Sum), 64'h3333);
        @(negedge clk);

        // Asynchronous reset at chunk index 2 aborts the operation.
        drive0(32'd1000, 32'd2000, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", 64'(bus0.ready), 64'd1);
        check("arst_busy", 64'(bus0.busy), 64'd0);
        check("arst_done", 64'(bus0.done), 64'd0);
        check("arst_sum", 64'(bus0.Sum), 64'd0);
        check("arst_cout", 64'(bus0.Cout), 64'd0);
        check("arst_ovf", 64'(bus0.Ovf), 64'd0);
        q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive0(32'd3, 32'd4, 1'b0, 1'b0);
        drain0("post_rst");
        check("post_rst_sum", 64'(bus0.Sum), 64'd7);

        // Random sweeps on the other configurations.
        sweep_go = 1'b1;
        n = 0;
        while (sweeps_done < 3 && n < 60000) begin @(negedge clk); n++; end
        check("sweep_complete", 64'(sweeps_done), 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
